// File: rtl/audio_router.sv
// Source selector with click-free crossfade: the output fades to silence before a
// new source is taken, then fades back in. Two-stage pipe: select/register, then scale.
//
// state    | meaning
// PASS     | gain at full scale, following active_src
// FADE_OUT | gain ramping down toward a pending source change or mute
// FADE_IN  | gain ramping up on the freshly loaded active_src
// MUTED    | gain held at zero until mute is released
module audio_router #(
    parameter int N_SRC     = 4,
    parameter int W         = 16,
    parameter int RAMP_LOG2 = 6,
    parameter int SW_SEL    = $clog2(N_SRC)
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [N_SRC*W-1:0]     src_data,
    input  logic                   src_valid,
    input  logic [SW_SEL-1:0]      sel,
    input  logic                   mute,
    output logic signed [W-1:0]    out_data,
    output logic                   out_valid,
    output logic [SW_SEL-1:0]      active_src,
    output logic                   busy
);

    localparam int GW = RAMP_LOG2 + 1;
    localparam int PW = W + GW + 1;
    localparam logic [GW-1:0] G_MAX = GW'(2 ** RAMP_LOG2);

    typedef enum logic [1:0] {PASS, FADE_OUT, FADE_IN, MUTED} state_t;

    state_t                state;
    logic [GW-1:0]         g;
    logic signed [W-1:0]   sel_sample;
    logic signed [W-1:0]   s1_sample;
    logic [GW-1:0]         s1_g;
    logic                  s1_valid;
    logic signed [PW-1:0]  prod;
    logic signed [W-1:0]   scaled;
    logic                  change_req;
    logic                  step_down;
    logic                  step_up;

    // Out-of-range selects fall through to silence.
    always_comb begin
        sel_sample = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (active_src == SW_SEL'(k)) begin
                sel_sample = src_data[k*W +: W];
            end
        end
    end

    assign change_req = mute || (sel != active_src);
    assign step_down  = (state == FADE_OUT) ||
                        ((state == PASS || state == FADE_IN) && change_req);
    assign step_up    = !step_down &&
                        ((state == FADE_IN) || (state == MUTED && !mute));

    // A transition strobe already applies the new state's gain step, so a full
    // source-to-source swap costs exactly 2*2^RAMP_LOG2 strobes.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= MUTED;
            g          <= '0;
            active_src <= '0;
            busy       <= 1'b0;
        end else if (src_valid) begin
            if (step_down) begin
                if (g <= GW'(1)) begin
                    g <= '0;
                    if (mute) begin
                        state <= MUTED;
                        busy  <= 1'b0;
                    end else begin
                        active_src <= sel;
                        state      <= FADE_IN;
                        busy       <= 1'b1;
                    end
                end else begin
                    g     <= g - GW'(1);
                    state <= FADE_OUT;
                    busy  <= 1'b1;
                end
            end else if (step_up) begin
                if (state == MUTED) begin
                    active_src <= sel;
                end
                g <= g + GW'(1);
                if (g + GW'(1) == G_MAX) begin
                    state <= PASS;
                    busy  <= 1'b0;
                end else begin
                    state <= FADE_IN;
                    busy  <= 1'b1;
                end
            end
        end
    end

    assign prod   = PW'(s1_sample) * PW'($signed({1'b0, s1_g}));
    assign scaled = W'(prod >>> RAMP_LOG2);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_g      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            s1_valid <= src_valid;
            if (src_valid) begin
                s1_sample <= sel_sample;
                s1_g      <= g;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_audio_router.sv
// Directed bench for audio_router: stimulus pushes expected samples into a queue,
// an independent monitor pops them on every out_valid and checks value and latency.
module tb_audio_router;

    localparam int N_SRC = 4;
    localparam int W     = 16;
    localparam int RL    = 6;
    localparam int SWS   = 3;

    logic                 CLOCK_50 = 1'b0;
    logic                 reset    = 1'b1;
    logic [N_SRC*W-1:0]   src_data = '0;
    logic                 src_valid = 1'b0;
    logic [SWS-1:0]       sel      = '0;
    logic                 mute     = 1'b0;
    logic [W-1:0]         out_data;
    logic                 out_valid;
    logic [SWS-1:0]       active_src;
    logic                 busy;

    audio_router #(.N_SRC(N_SRC), .W(W), .RAMP_LOG2(RL), .SW_SEL(SWS)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .sel        (sel),
        .mute       (mute),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .active_src (active_src),
        .busy       (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_out_valid: got pulse at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", {16'h0, out_data}, {16'h0, e.d});
                chk("latency", cyc - e.c, 2);
            end
        end
    end

    task automatic set_src(input int k, input logic [15:0] v);
        src_data[k*W +: W] = v;
    endtask

    // One strobe; gap=0 keeps src_valid high so the next call is back-to-back.
    task automatic strobe(input logic [15:0] e, input int gap = 1,
                          input int k = -1, input logic [15:0] v = 16'h0);
        exp_t x;
        @(negedge CLOCK_50);
        if (k >= 0) set_src(k, v);
        src_valid = 1'b1;
        x.d = e;
        x.c = cyc;
        sb.push_back(x);
        if (gap > 0) begin
            @(negedge CLOCK_50);
            src_valid = 1'b0;
            repeat (gap - 1) @(negedge CLOCK_50);
        end
    endtask

    function automatic int gmin(input int a);
        return (a > 64) ? 64 : a;
    endfunction

    initial begin
        set_src(0, 16'h1234);
        set_src(1, 16'h4000);
        set_src(2, 16'hC000);
        set_src(3, 16'h2000);
        repeat (3) @(negedge CLOCK_50);
        chk("rst_out_data", {16'h0, out_data}, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_active", active_src, 0);
        reset = 1'b0;

        // Fade in on source 1 from reset
        sel = 3'd1;
        mute = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            strobe(16'(gmin(i - 1) * 'h100));
            if (i == 1)  chk("a_active_first", active_src, 1);
            if (i == 63) chk("a_busy_63", busy, 1);
            if (i == 64) chk("a_busy_64", busy, 0);
        end
        chk("a_active", active_src, 1);

        // Back-to-back strobes at full gain
        strobe(16'h0040, 0, 1, 16'h0040);
        strobe(16'hFFC0, 0, 1, 16'hFFC0);
        strobe(16'h1000, 1, 1, 16'h1000);
        set_src(1, 16'h4000);

        // Source 1 -> source 2 crossfade
        sel = 3'd2;
        for (int j = 1; j <= 64; j++) begin
            strobe(16'((65 - j) * 'h100));
            if (j == 63) chk("b_active_63", active_src, 1);
            if (j == 64) chk("b_active_64", active_src, 2);
        end
        for (int j = 0; j <= 65; j++) begin
            strobe(16'(-256 * gmin(j)));
            if (j == 62) chk("b_busy_62", busy, 1);
            if (j == 63) chk("b_busy_63", busy, 0);
        end

        // Interrupted fade-in: reverse from g=20
        sel = 3'd3;
        for (int j = 1; j <= 64; j++) strobe(16'(-256 * (65 - j)));
        for (int j = 0; j <= 19; j++) strobe(16'(j * 'h80));
        chk("c_busy", busy, 1);
        chk("c_active3", active_src, 3);
        sel = 3'd1;
        for (int j = 0; j <= 19; j++) begin
            strobe(16'((20 - j) * 'h80));
            if (j == 18) chk("c_active_18", active_src, 3);
            if (j == 19) chk("c_active_19", active_src, 1);
        end
        for (int j = 0; j <= 65; j++) strobe(16'(gmin(j) * 'h100));
        chk("c_busy_end", busy, 0);

        // Mute, then unmute onto an out-of-range source
        mute = 1'b1;
        for (int j = 0; j <= 63; j++) begin
            strobe(16'((64 - j) * 'h100));
            if (j == 62) chk("d_busy_62", busy, 1);
            if (j == 63) chk("d_busy_63", busy, 0);
        end
        repeat (3) strobe(16'h0000);
        chk("d_muted_busy", busy, 0);
        chk("d_muted_active", active_src, 1);
        mute = 1'b0;
        sel = 3'd5;
        strobe(16'h0000);
        chk("d_active5", active_src, 5);
        chk("d_busy_in", busy, 1);
        for (int j = 1; j <= 64; j++) begin
            strobe(16'h0000);
            if (j == 62) chk("d_busy_j62", busy, 1);
            if (j == 63) chk("d_busy_j63", busy, 0);
        end
        chk("d_active5_end", active_src, 5);

        // Floor rounding of negative products at small gains
        sel = 3'd0;
        for (int j = 1; j <= 64; j++) strobe(16'h0000);
        chk("e_active0", active_src, 0);
        strobe(16'h0000);
        strobe(16'hFE00, 1, 0, 16'h8001);
        strobe(16'hFFFF, 1, 0, 16'hFFFF);
        strobe(16'h0000, 1, 0, 16'h0001);
        strobe(16'hFFFC, 1, 0, 16'hFFC1);
        repeat (4) @(negedge CLOCK_50);
        chk("e_drained", sb.size(), 0);

        // Reset while a sample is in flight: no pulse may emerge
        sel = 3'd2;
        @(negedge CLOCK_50);
        src_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        src_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("f_out_data", {16'h0, out_data}, 0);
        chk("f_out_valid", out_valid, 0);
        chk("f_busy", busy, 0);
        chk("f_active", active_src, 0);
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        strobe(16'h0000);
        chk("f_active2", active_src, 2);
        chk("f_busy_in", busy, 1);
        strobe(16'hFF00);
        repeat (5) @(negedge CLOCK_50);
        chk("f_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
